// File: rtl/ram_output_bank_pkg.sv
// ram_out_pkg: shared definitions for the output-unit RAM bank.
//   - default word/address widths
//   - stream sequencer state encoding
package ram_out_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } strm_state_e;

endpackage

// File: rtl/ram_output_bank_if.sv
// ram_output_bank_if: bus bundle for the output RAM bank.
//   write port : wr_en, wr_addr, wr_data
//   random read: rd_en, rd_addr -> rd_data, rd_valid
//   stream     : strm_start, strm_ready -> strm_busy, strm_data, strm_addr,
//                strm_valid, strm_done
// master = writer/consumer side, slave = RAM bank side.
interface ram_output_bank_if
    import ram_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  strm_start;
    logic                  strm_busy;
    logic [DATA_WIDTH-1:0] strm_data;
    logic [ADDR_WIDTH-1:0] strm_addr;
    logic                  strm_valid;
    logic                  strm_ready;
    logic                  strm_done;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, strm_start, strm_ready,
        input  rd_data, rd_valid, strm_busy, strm_data, strm_addr, strm_valid, strm_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, strm_start, strm_ready,
        output rd_data, rd_valid, strm_busy, strm_data, strm_addr, strm_valid, strm_done
    );

endinterface

// File: rtl/ram_sdp_core.sv
// ram_sdp_core: simple-dual-port RAM, one write port and one enable-gated
// registered read port.
//   clk, rst_n        : clock, async active-low reset (read register only)
//   wr_en/addr/data   : write port
//   rd_en/rd_addr     : read request, data appears on rd_data after the edge
//   rd_data           : registered read word, held while rd_en is low
// Optional macro RAM_OUT_WR_FWD_EN: a read on the same edge and address as a
// write returns the incoming wr_data instead of the old array contents.
module ram_sdp_core
    import ram_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Array has no reset so contents survive rst_n.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_word;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef RAM_OUT_WR_FWD_EN
    assign rd_word = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
    assign rd_word = mem[rd_addr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= rd_word;
    end

endmodule

// File: rtl/ram_output_bank.sv
// ram_output_bank: output-unit RAM with random read and full-array streaming.
//   clk, rst_n : clock, async active-low reset
//   bus        : ram_output_bank_if.slave (write, random read, stream ports)
// The single read port of ram_sdp_core is shared: stream issues win, random
// reads are only accepted while the sequencer is idle.
// Optional macro RAM_OUT_WR_FWD_EN enables write-to-read forwarding in the core.
module ram_output_bank
    import ram_out_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_output_bank_if.slave bus
);
    strm_state_e           state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic                  issue, rand_acc, last_acc;
    logic                  core_rd_en;
    logic [ADDR_WIDTH-1:0] core_rd_addr;
    logic [DATA_WIDTH-1:0] core_q;

    logic                  rd_valid_r, strm_valid_r, strm_done_r;
    logic [ADDR_WIDTH-1:0] strm_addr_r;

    // The core register holds whichever read came last; src_strm records the
    // owner, and the other output is served from its hold register, which
    // snapshots core_q on the edge ownership changes.
    logic                  src_strm;
    logic [DATA_WIDTH-1:0] rd_hold, strm_hold;

    assign issue    = (state == ST_RUN) && (!strm_valid_r || bus.strm_ready);
    assign rand_acc = bus.rd_en && (state == ST_IDLE);
    assign last_acc = (state == ST_DRAIN) && bus.strm_ready;

    assign core_rd_en   = issue || rand_acc;
    assign core_rd_addr = issue ? ptr : bus.rd_addr;

    ram_sdp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (core_rd_en),
        .rd_addr (core_rd_addr),
        .rd_data (core_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            strm_valid_r <= 1'b0;
            strm_done_r  <= 1'b0;
            strm_addr_r  <= '0;
        end else begin
            strm_done_r <= 1'b0;
            case (state)
                // A start coinciding with the done pulse is dropped.
                ST_IDLE: if (bus.strm_start && !strm_done_r) begin
                    state <= ST_RUN;
                    ptr   <= '0;
                end
                ST_RUN: if (issue) begin
                    strm_valid_r <= 1'b1;
                    strm_addr_r  <= ptr;
                    ptr          <= ptr + ADDR_WIDTH'(1);
                    if (&ptr) state <= ST_DRAIN;
                end
                ST_DRAIN: if (last_acc) begin
                    strm_valid_r <= 1'b0;
                    strm_done_r  <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            src_strm   <= 1'b0;
            rd_hold    <= '0;
            strm_hold  <= '0;
        end else begin
            rd_valid_r <= rand_acc;
            if (issue && !src_strm) begin
                rd_hold  <= core_q;
                src_strm <= 1'b1;
            end
            if (rand_acc && src_strm) begin
                strm_hold <= core_q;
                src_strm  <= 1'b0;
            end
        end
    end

    assign bus.rd_data    = src_strm ? rd_hold : core_q;
    assign bus.rd_valid   = rd_valid_r;
    assign bus.strm_data  = src_strm ? core_q : strm_hold;
    assign bus.strm_addr  = strm_addr_r;
    assign bus.strm_valid = strm_valid_r;
    assign bus.strm_done  = strm_done_r;
    assign bus.strm_busy  = (state != ST_IDLE);

endmodule
